// File: rtl/core_control_fsm.sv
// Multicycle control FSM for the RV32I core: sequences fetch/decode/execute/memory/writeback
// over one shared ALU and memory port, and counts retired instructions.
module core_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    input  logic             branch_taken_i,
    output logic [1:0]       ALU_CO_o,
    output logic             is_immediate_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             lord_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_source_o,
    output logic             reg_write_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instret_o
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, LUI, AUIPC, ALU_WB, MEM_ADDR,
        MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JAL, JALR, ILLEGAL
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic             retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        retire         = 1'b0;
        ALU_CO_o       = 2'b00;
        is_immediate_o = 1'b0;
        alu_src_a_o    = 2'b00;
        alu_src_b_o    = 2'b00;
        mem_read_o     = 1'b0;
        mem_write_o    = 1'b0;
        lord_o         = 1'b0;
        ir_write_o     = 1'b0;
        pc_write_o     = 1'b0;
        pc_source_o    = 1'b0;
        reg_write_o    = 1'b0;
        mem_to_reg_o   = 2'b00;

        unique case (state_q)
            FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                unique case (opcode_i)
                    OP_R:               state_d = EXEC_R;
                    OP_I:               state_d = EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
                    OP_BRANCH:          state_d = BRANCH;
                    OP_JAL:             state_d = JAL;
                    OP_JALR:            state_d = JALR;
                    OP_LUI:             state_d = LUI;
                    OP_AUIPC:           state_d = AUIPC;
                    default:            state_d = ILLEGAL;
                endcase
            end
            EXEC_R: begin
                alu_src_a_o = 2'b10;
                ALU_CO_o    = 2'b10;
                state_d     = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a_o    = 2'b10;
                alu_src_b_o    = 2'b10;
                ALU_CO_o       = 2'b10;
                is_immediate_o = 1'b1;
                state_d        = ALU_WB;
            end
            LUI: begin
                alu_src_a_o = 2'b11;
                alu_src_b_o = 2'b10;
                state_d     = ALU_WB;
            end
            AUIPC: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                state_d     = ALU_WB;
            end
            ALU_WB: begin
                reg_write_o = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b10;
                // opcode bit5 separates store (0100011) from load (0000011)
                state_d     = opcode_i[5] ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_read_o = 1'b1;
                lord_o     = 1'b1;
                if (mem_ready_i) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'b01;
                retire       = 1'b1;
                state_d      = FETCH;
            end
            MEM_WRITE: begin
                mem_write_o = 1'b1;
                lord_o      = 1'b1;
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            BRANCH: begin
                alu_src_a_o = 2'b10;
                ALU_CO_o    = 2'b01;
                pc_write_o  = branch_taken_i;
                pc_source_o = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            JAL: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'b10;
                pc_write_o   = 1'b1;
                pc_source_o  = 1'b1;
                retire       = 1'b1;
                state_d      = FETCH;
            end
            JALR: begin
                alu_src_a_o  = 2'b10;
                alu_src_b_o  = 2'b10;
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'b10;
                pc_write_o   = 1'b1;
                retire       = 1'b1;
                state_d      = FETCH;
            end
            ILLEGAL: state_d = ILLEGAL;
            default: state_d = FETCH;
        endcase

        // Strobes are forced quiet while reset is held, even though the state is already FETCH.
        if (!rst_n) begin
            ALU_CO_o       = 2'b00;
            is_immediate_o = 1'b0;
            alu_src_a_o    = 2'b00;
            alu_src_b_o    = 2'b00;
            mem_read_o     = 1'b0;
            mem_write_o    = 1'b0;
            lord_o         = 1'b0;
            ir_write_o     = 1'b0;
            pc_write_o     = 1'b0;
            pc_source_o    = 1'b0;
            reg_write_o    = 1'b0;
            mem_to_reg_o   = 2'b00;
        end
    end

    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    assign illegal_d = illegal_q | (state_d == ILLEGAL);
    assign instret_o = instret_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_core_control_fsm.sv
// Directed bench for core_control_fsm: walks each instruction class and checks strobes per cycle.
module tb_core_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        ready;
    logic        taken;
    logic [1:0]  co, src_a, src_b, mtr;
    logic        is_imm, mrd, mwr, lord, irw, pcw, pcs, rw, ill;
    logic [31:0] instret;
    logic [16:0] outs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    core_control_fsm #(.CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode_i       (opcode),
        .mem_ready_i    (ready),
        .branch_taken_i (taken),
        .ALU_CO_o       (co),
        .is_immediate_o (is_imm),
        .alu_src_a_o    (src_a),
        .alu_src_b_o    (src_b),
        .mem_read_o     (mrd),
        .mem_write_o    (mwr),
        .lord_o         (lord),
        .ir_write_o     (irw),
        .pc_write_o     (pcw),
        .pc_source_o    (pcs),
        .reg_write_o    (rw),
        .mem_to_reg_o   (mtr),
        .illegal_o      (ill),
        .instret_o      (instret)
    );

    assign outs = {co, is_imm, src_a, src_b, mrd, mwr, lord, irw, pcw, pcs, rw, mtr, ill};

    // Field order matches `outs`.
    function automatic logic [16:0] pk(input logic [1:0] e_co, input logic e_imm,
                                       input logic [1:0] e_a, input logic [1:0] e_b,
                                       input logic e_mr, input logic e_mw, input logic e_ld,
                                       input logic e_irw, input logic e_pcw, input logic e_pcs,
                                       input logic e_rw, input logic [1:0] e_mtr, input logic e_il);
        return {e_co, e_imm, e_a, e_b, e_mr, e_mw, e_ld, e_irw, e_pcw, e_pcs, e_rw, e_mtr, e_il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [16:0] Z       = 17'd0;
    localparam logic [6:0]  OP_ADD  = 7'b0110011;
    localparam logic [6:0]  OP_ADDI = 7'b0010011;
    localparam logic [6:0]  OP_LW   = 7'b0000011;
    localparam logic [6:0]  OP_SW   = 7'b0100011;
    localparam logic [6:0]  OP_BEQ  = 7'b1100011;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    localparam logic [6:0]  OP_LUI  = 7'b0110111;
    localparam logic [6:0]  OP_AUI  = 7'b0010111;

    logic [16:0] fetch_rdy, fetch_wait, decode;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        fetch_rdy  = pk(2'd0, 0, 2'd0, 2'd1, 1, 0, 0, 1, 1, 0, 0, 2'd0, 0);
        fetch_wait = pk(2'd0, 0, 2'd0, 2'd1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0);
        decode     = pk(2'd0, 0, 2'd1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0);

        rst_n = 1'b0; ready = 1'b0; taken = 1'b0; opcode = OP_ADD;
        step(); step();
        chk("reset_outs", 32'(outs), 32'(Z));
        chk("reset_instret", instret, 32'd0);

        // ADD, ready tied high: 4 cycles
        ready = 1'b1;
        rst_n = 1'b1;
        #1 chk("add_fetch", 32'(outs), 32'(fetch_rdy));
        step(); chk("add_decode", 32'(outs), 32'(decode));
        step(); chk("add_exec_r", 32'(outs), 32'(pk(2'd2, 0, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0)));
        step(); chk("add_alu_wb", 32'(outs), 32'(pk(2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0)));
        chk("add_instret_pre", instret, 32'd0);
        step(); chk("add_back_fetch", 32'(outs), 32'(fetch_rdy));
        chk("add_instret", instret, 32'd1);

        // LW, ready withheld 3 cycles in MEM_READ
        opcode = OP_LW;
        step(); chk("lw_decode", 32'(outs), 32'(decode));
        step(); chk("lw_mem_addr", 32'(outs), 32'(pk(2'd0, 0, 2'd2, 2'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0)));
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("lw_mem_read_wait", 32'(outs), 32'(pk(2'd0, 0, 2'd0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 0)));
        end
        step(); ready = 1'b1;
        chk("lw_mem_read_rdy", 32'(outs), 32'(pk(2'd0, 0, 2'd0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 0)));
        step(); chk("lw_mem_wb", 32'(outs), 32'(pk(2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 0)));
        step(); chk("lw_instret", instret, 32'd2);

        // SW, with one FETCH wait cycle and one MEM_WRITE wait cycle
        opcode = OP_SW; ready = 1'b0;
        #1 chk("sw_fetch_wait", 32'(outs), 32'(fetch_wait));
        step(); chk("sw_fetch_hold", 32'(outs), 32'(fetch_wait));
        ready = 1'b1;
        #1 chk("sw_fetch_rdy", 32'(outs), 32'(fetch_rdy));
        step(); chk("sw_decode", 32'(outs), 32'(decode));
        step(); ready = 1'b0;
        step(); chk("sw_mem_write_wait", 32'(outs), 32'(pk(2'd0, 0, 2'd0, 2'd0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 0)));
        chk("sw_instret_hold", instret, 32'd2);
        ready = 1'b1;
        step(); chk("sw_instret", instret, 32'd3);
        chk("sw_back_fetch", 32'(outs), 32'(fetch_rdy));

        // BEQ taken then not taken
        opcode = OP_BEQ; taken = 1'b1;
        step(); step();
        chk("beq_taken", 32'(outs), 32'(pk(2'd1, 0, 2'd2, 2'd0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 0)));
        step(); chk("beq_taken_instret", instret, 32'd4);
        taken = 1'b0;
        step(); step();
        chk("beq_not_taken", 32'(outs), 32'(pk(2'd1, 0, 2'd2, 2'd0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0)));
        step(); chk("beq_nt_instret", instret, 32'd5);

        // JAL, JALR
        opcode = OP_JAL;
        step(); step();
        chk("jal", 32'(outs), 32'(pk(2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 1, 1, 2'd2, 0)));
        step();
        opcode = OP_JALR;
        step(); step();
        chk("jalr", 32'(outs), 32'(pk(2'd0, 0, 2'd2, 2'd2, 0, 0, 0, 0, 1, 0, 1, 2'd2, 0)));
        step(); chk("jalr_instret", instret, 32'd7);

        // ADDI, LUI, AUIPC
        opcode = OP_ADDI;
        step(); step();
        chk("addi_exec_i", 32'(outs), 32'(pk(2'd2, 1, 2'd2, 2'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0)));
        step(); step();
        opcode = OP_LUI;
        step(); step();
        chk("lui", 32'(outs), 32'(pk(2'd0, 0, 2'd3, 2'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0)));
        step(); step();
        opcode = OP_AUI;
        step(); step();
        chk("auipc", 32'(outs), 32'(pk(2'd0, 0, 2'd1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0)));
        step(); step();
        chk("auipc_instret", instret, 32'd10);

        // Unsupported opcode: absorbing ILLEGAL
        opcode = 7'b0000000;
        step(); step();
        for (int i = 0; i < 20; i++) begin
            chk("illegal_state", 32'(outs), 32'(pk(2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1)));
            step();
        end
        chk("illegal_instret", instret, 32'd10);

        // Reset asserted mid-MEM_READ
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; opcode = OP_LW; ready = 1'b1;
        step(); step(); ready = 1'b0;
        step();
        chk("rst_pre_mem_read", 32'(outs), 32'(pk(2'd0, 0, 2'd0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 0)));
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_outs", 32'(outs), 32'(Z));
        chk("rst_mid_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_release_fetch", 32'(outs), 32'(fetch_wait));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
